// File: rtl/fm_da_agc.sv
// DC-blocks the FIR output, applies window-peak AGC (Q3.5 gain) and emits offset-binary DAC codes.
// Latency 2 cycles at one sample per cycle; no backpressure, outputs hold while out_valid is low.
module fm_da_agc #(
    parameter int WIN_LEN   = 4096,
    parameter int TARGET    = 96,
    parameter int HYST      = 16,
    parameter int DC_SHIFT  = 8,
    parameter int GAIN_INIT = 32,
    parameter int GAIN_MIN  = 4,
    parameter int GAIN_MAX  = 255
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       agc_en,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_otr,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       sat_flag,
    output logic [7:0] gain
);

    localparam int CNT_W = $clog2(WIN_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_LEN - 1);
    localparam logic [10:0] P_HI = 11'(TARGET + HYST);
    localparam logic [10:0] P_LO = 11'(TARGET - HYST);
    localparam logic [7:0] G_INIT = 8'(GAIN_INIT);
    localparam logic [7:0] G_MIN  = 8'(GAIN_MIN);
    localparam logic [7:0] G_MAX  = 8'(GAIN_MAX);

    typedef enum logic {S_MEASURE, S_UPDATE} state_t;

    state_t             r_state, w_state_nxt;
    logic               w_upd;
    logic signed [16:0] r_acc;
    logic signed [16:0] w_dc, w_in_ext, w_diff;
    logic signed [8:0]  w_x_ac;
    logic [8:0]         w_abs;
    logic [7:0]         w_mag;
    logic               r_s1_vld;
    logic signed [8:0]  r_s1_x;
    logic signed [16:0] w_p, w_y;
    logic [7:0]         w_y_sat;
    logic               w_sat;
    logic [7:0]         r_gain, w_gain_nxt, w_step, w_dec;
    logic [10:0]        w_pk_scaled;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_peak;
    logic               r_otr_seen;

    // Stage 1: leaky-integrator DC estimate subtracted from the incoming sample
    assign w_dc     = r_acc >>> DC_SHIFT;
    assign w_in_ext = {{9{in_data[7]}}, in_data};
    assign w_diff   = w_in_ext - w_dc;
    assign w_x_ac   = w_diff[8:0];
    assign w_abs    = w_x_ac[8] ? (9'd0 - w_x_ac) : w_x_ac;
    assign w_mag    = w_abs[8] ? 8'hFF : w_abs[7:0];

    // Stage 2: signed sample times unsigned Q3.5 gain, then clip to 8 bits
    assign w_p = {{8{r_s1_x[8]}}, r_s1_x} * $signed({9'd0, r_gain});
    assign w_y = w_p >>> 5;

    always_comb begin
        w_y_sat = w_y[7:0];
        w_sat   = 1'b0;
        if (w_y > 17'sd127) begin
            w_y_sat = 8'h7F;
            w_sat   = 1'b1;
        end else if (w_y < -17'sd128) begin
            w_y_sat = 8'h80;
            w_sat   = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_acc     <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_x    <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'd128;
            sat_flag  <= 1'b0;
        end else begin
            r_s1_vld  <= in_valid;
            out_valid <= r_s1_vld;
            if (in_valid) begin
                r_s1_x <= w_x_ac;
                r_acc  <= r_acc + w_diff;
            end
            if (r_s1_vld) begin
                out_data <= w_y_sat ^ 8'h80;
                sat_flag <= w_sat;
            end
        end
    end

    // Window FSM
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) r_state <= S_MEASURE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!agc_en) begin
            w_state_nxt = S_MEASURE;
        end else begin
            case (r_state)
                S_MEASURE: if (in_valid && r_cnt == CNT_LAST) w_state_nxt = S_UPDATE;
                S_UPDATE:  w_state_nxt = S_MEASURE;
                default:   w_state_nxt = S_MEASURE;
            endcase
        end
    end

    always_comb begin
        w_upd = agc_en && (r_state == S_UPDATE);
    end

    // Gain decision from the window peak as it would appear at the output
    assign w_pk_scaled = 11'(({8'd0, r_peak} * {8'd0, r_gain}) >> 5);
    assign w_step      = (r_gain[7:3] == 5'd0) ? 8'd1 : {3'd0, r_gain[7:3]};
    assign w_dec       = r_gain - w_step;

    always_comb begin
        w_gain_nxt = r_gain;
        if (r_otr_seen || w_pk_scaled > P_HI)
            w_gain_nxt = (w_dec < G_MIN) ? G_MIN : w_dec;
        else if (w_pk_scaled < P_LO)
            w_gain_nxt = (r_gain >= G_MAX) ? G_MAX : r_gain + 8'd1;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_gain     <= G_INIT;
            r_cnt      <= '0;
            r_peak     <= '0;
            r_otr_seen <= 1'b0;
        end else if (!agc_en) begin
            r_gain     <= G_INIT;
            r_cnt      <= '0;
            r_peak     <= '0;
            r_otr_seen <= 1'b0;
        end else if (w_upd) begin
            r_gain     <= w_gain_nxt;
            r_cnt      <= in_valid ? CNT_W'(1) : '0;
            r_peak     <= in_valid ? w_mag : 8'd0;
            r_otr_seen <= in_valid & in_otr;
        end else if (in_valid) begin
            r_cnt      <= r_cnt + CNT_W'(1);
            if (w_mag > r_peak) r_peak <= w_mag;
            r_otr_seen <= r_otr_seen | in_otr;
        end
    end

    assign gain = r_gain;

endmodule

// File: tb/tb_fm_da_agc.sv
// Directed bench for fm_da_agc with a 16-sample window.
module tb_fm_da_agc;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       agc_en;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_otr;
    logic       out_valid;
    logic [7:0] out_data;
    logic       sat_flag;
    logic [7:0] gain;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 sys_clk = ~sys_clk;

    fm_da_agc #(.WIN_LEN(16)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .agc_en   (agc_en),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_otr   (in_otr),
        .out_valid(out_valid),
        .out_data (out_data),
        .sat_flag (sat_flag),
        .gain     (gain)
    );

    task automatic step(input logic v, input logic [7:0] d, input logic o);
        in_valid = v;
        in_data  = d;
        in_otr   = o;
        @(posedge sys_clk);
        #1;
    endtask

    // 16 zero samples, optional overrange on the 6th, then an idle UPDATE cycle
    task automatic zero_window(input logic otr_mid);
        for (int i = 0; i < 16; i++) step(1'b1, 8'd0, (i == 5) ? otr_mid : 1'b0);
        step(1'b0, 8'd0, 1'b0);
    endtask

    task automatic test_reset;
        sys_rst = 1'b0; agc_en = 1'b0; in_valid = 1'b0; in_data = 8'd0; in_otr = 1'b0;
        #1 sys_rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        step(1'b0, 8'd0, 1'b0);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0d want 0", out_valid); end
        n_tests++; if (out_data !== 8'd128) begin n_fail++; $display("FAIL reset_out_data got %0d want 128", out_data); end
        n_tests++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL reset_sat_flag got %0d want 0", sat_flag); end
        n_tests++; if (gain !== 8'd32) begin n_fail++; $display("FAIL reset_gain got %0d want 32", gain); end
    endtask

    task automatic test_bypass;
        step(1'b1, 8'd40, 1'b0);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_early got %0d want 0", out_valid); end
        step(1'b0, 8'd0, 1'b0);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bypass_valid got %0d want 1", out_valid); end
        n_tests++; if (out_data !== 8'd168) begin n_fail++; $display("FAIL bypass_data got %0d want 168", out_data); end
        n_tests++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL bypass_sat got %0d want 0", sat_flag); end
        step(1'b0, 8'd0, 1'b0);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_drop got %0d want 0", out_valid); end
        n_tests++; if (out_data !== 8'd168) begin n_fail++; $display("FAIL bypass_hold got %0d want 168", out_data); end
    endtask

    task automatic test_reset_mid;
        step(1'b1, 8'd10, 1'b0);
        step(1'b1, 8'd20, 1'b0);
        n_tests++; if (out_data !== 8'd138) begin n_fail++; $display("FAIL midrst_pre got %0d want 138", out_data); end
        sys_rst = 1'b1;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %0d want 0", out_valid); end
        n_tests++; if (out_data !== 8'd128) begin n_fail++; $display("FAIL midrst_data got %0d want 128", out_data); end
        n_tests++; if (gain !== 8'd32) begin n_fail++; $display("FAIL midrst_gain got %0d want 32", gain); end
        in_valid = 1'b0;
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        step(1'b0, 8'd0, 1'b0);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_inflight got %0d want 0", out_valid); end
        step(1'b1, 8'd40, 1'b0);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_early got %0d want 0", out_valid); end
        step(1'b0, 8'd0, 1'b0);
        n_tests++; if (out_valid !== 1'b1 || out_data !== 8'd168) begin n_fail++; $display("FAIL midrst_first got v=%0d d=%0d want v=1 d=168", out_valid, out_data); end
    endtask

    task automatic test_dc;
        for (int i = 0; i < 20000; i++) step(1'b1, 8'd50, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dc_valid got %0d want 1", out_valid); end
        n_tests++; if (out_data < 8'd127 || out_data > 8'd129) begin n_fail++; $display("FAIL dc_converge got %0d want 127..129", out_data); end
        n_tests++; if (gain !== 8'd32) begin n_fail++; $display("FAIL dc_gain got %0d want 32", gain); end
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
    endtask

    task automatic test_window_gap;
        agc_en = 1'b1;
        for (int i = 0; i < 15; i++) step(1'b1, 8'd0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'd0, 1'b1);
        step(1'b1, 8'd0, 1'b0);
        n_tests++; if (gain !== 8'd32) begin n_fail++; $display("FAIL gap_before got %0d want 32", gain); end
        step(1'b0, 8'd0, 1'b0);
        n_tests++; if (gain !== 8'd33) begin n_fail++; $display("FAIL gap_update got %0d want 33", gain); end
    endtask

    task automatic test_overrange;
        repeat (31) zero_window(1'b0);
        n_tests++; if (gain !== 8'd64) begin n_fail++; $display("FAIL otr_rise got %0d want 64", gain); end
        zero_window(1'b1);
        n_tests++; if (gain !== 8'd56) begin n_fail++; $display("FAIL otr_cut got %0d want 56", gain); end
    endtask

    task automatic test_saturation;
        repeat (8) zero_window(1'b0);
        n_tests++; if (gain !== 8'd64) begin n_fail++; $display("FAIL sat_gain got %0d want 64", gain); end
        step(1'b1, 8'd100, 1'b0);
        step(1'b1, 8'h9C, 1'b0);
        n_tests++; if (out_data !== 8'd255 || sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_pos got d=%0d s=%0d want d=255 s=1", out_data, sat_flag); end
        step(1'b1, 8'd0, 1'b0);
        n_tests++; if (out_data !== 8'd0 || sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_neg got d=%0d s=%0d want d=0 s=1", out_data, sat_flag); end
        step(1'b1, 8'd0, 1'b0);
        n_tests++; if (out_data !== 8'd128 || sat_flag !== 1'b0) begin n_fail++; $display("FAIL sat_clear got d=%0d s=%0d want d=128 s=0", out_data, sat_flag); end
        for (int i = 0; i < 12; i++) step(1'b1, 8'd0, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        n_tests++; if (gain !== 8'd56) begin n_fail++; $display("FAIL sat_peak_cut got %0d want 56", gain); end
    endtask

    task automatic test_gain_min;
        repeat (30) zero_window(1'b1);
        n_tests++; if (gain !== 8'd4) begin n_fail++; $display("FAIL gmin_reach got %0d want 4", gain); end
        zero_window(1'b1);
        n_tests++; if (gain !== 8'd4) begin n_fail++; $display("FAIL gmin_hold got %0d want 4", gain); end
    endtask

    task automatic test_gain_up;
        int mx;
        int mn;
        logic sat_seen;
        agc_en = 1'b0;
        step(1'b0, 8'd0, 1'b0);
        n_tests++; if (gain !== 8'd32) begin n_fail++; $display("FAIL gup_bypass got %0d want 32", gain); end
        agc_en = 1'b1;
        for (int i = 0; i < 808; i++) step(1'b1, i[0] ? 8'hEC : 8'h14, 1'b0);
        n_tests++; if (gain !== 8'd82) begin n_fail++; $display("FAIL gup_mid got %0d want 82", gain); end
        for (int i = 808; i < 2000; i++) step(1'b1, i[0] ? 8'hEC : 8'h14, 1'b0);
        n_tests++; if (gain !== 8'd128) begin n_fail++; $display("FAIL gup_settle got %0d want 128", gain); end
        mx = 0; mn = 255; sat_seen = 1'b0;
        for (int i = 2000; i < 2016; i++) begin
            step(1'b1, i[0] ? 8'hEC : 8'h14, 1'b0);
            if (int'(out_data) > mx) mx = int'(out_data);
            if (int'(out_data) < mn) mn = int'(out_data);
            sat_seen = sat_seen | sat_flag;
        end
        n_tests++; if (mx != 208 || mn != 48) begin n_fail++; $display("FAIL gup_swing got max=%0d min=%0d want 208/48", mx, mn); end
        n_tests++; if (sat_seen !== 1'b0) begin n_fail++; $display("FAIL gup_sat got %0d want 0", sat_seen); end
        n_tests++; if (gain !== 8'd128) begin n_fail++; $display("FAIL gup_hold got %0d want 128", gain); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_reset_mid();
        test_dc();
        test_window_gap();
        test_overrange();
        test_saturation();
        test_gain_min();
        test_gain_up();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
